sprite_loader: RTL
==================

# sprite_loader

Double-buffered write port for sprite bitmap memory. Accepts a valid/ready byte stream and assembles the bytes into sprite rows. The rows are written into a back bank. The back bank is swapped to the front only on a frame pulse, so a sprite is never altered mid-frame. The front bank is read row-by-row by the sprite renderer over `rd_row`/`rd_data`, replacing its fixed `.mem` ROM when bitmaps must change at run time.

## Interface
- `SPR_WIDTH`, 8: sprite width in pixels (1 bpp); must be a multiple of 8.
- `SPR_HEIGHT`, 8: sprite height in rows; ≥ 2.
- `clk`  in  1  pixel clock (clk25 domain).
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `frame`  in  1  one-cycle pulse at start of vertical blanking.
- `in_data`  in  8  bitmap byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `rd_row`  in  $clog2(SPR_HEIGHT)  front-bank row address.
- `rd_data`  out  SPR_WIDTH  registered front-bank row; bit SPR_WIDTH-1 = leftmost pixel.
- `pending`  out  1  complete image waiting in back bank.
- `loaded`  out  1  front bank holds a valid image.
- `swap`  out  1  one-cycle pulse: banks exchanged.

## Operation
- Storage: two banks of SPR_HEIGHT × SPR_WIDTH bits. `bank_sel` names the front bank. Writes go only to `!bank_sel`; reads come only from `bank_sel`.
- Byte order: BPR = SPR_WIDTH/8 bytes per row, rows top to bottom. The first byte of a row fills bits [SPR_WIDTH-1 -: 8]; later bytes fill progressively lower bits.
- Transfer: a byte transfers on a rising edge with `in_valid && in_ready`. `in_valid` may drop at any time without penalty.
- Counters: `byte_cnt` (0..BPR-1) and `row_cnt` (0..SPR_HEIGHT-1). A row shift register collects bytes. On the accept of byte BPR-1, the assembled word (shift reg + incoming byte) is written to back bank `[row_cnt]` on that same edge.
- State machine:
  - LOAD (reset state): `in_ready`=1. Accepting the last byte of row SPR_HEIGHT-1 → PEND, with counters cleared.
  - PEND: `in_ready`=0, `pending`=1. `frame`=1 → `bank_sel` toggles, `loaded` is set, next state LOAD.
  - `frame` in LOAD is ignored.
- `rd_data`: equals front bank `[rd_row]` registered when `loaded`=1, and 0 when `loaded`=0.
- Back-bank contents during a load are unspecified to readers; readers can never observe them.

## Timing
- Reset values (cycle after `rst` sampled high): state LOAD, counters 0, `bank_sel`=0, `loaded`=0, `pending`=0, `swap`=0, `rd_data`=0.
- `in_ready` is forced 0 while `rst`=1 and is 1 on the first cycle after deassertion.
- Bank RAM contents are not cleared by reset; `loaded`=0 masks them.
- Read latency: 1 clock, `rd_row` sampled at edge N → `rd_data` valid after N.
- Swap timing: `frame` sampled at edge E in PEND toggles `bank_sel` at E. `swap`=1 for exactly the cycle after E. `rd_data` reflects the new bank from edge E+1.
- `pending` falls and `in_ready` rises in the cycle after E.
- Last byte accepted on the same edge as `frame`: no swap; `pending` rises after that edge, and the next `frame` swaps.
- Consecutive `frame` pulses while in LOAD: no effect.
- Throughput: 1 byte/clock sustained. A full load takes SPR_HEIGHT·BPR accepted cycles.
- Reset mid-load: partial data is discarded, `loaded`=0, and the next byte after reset is row 0 byte 0.

## Test plan
- **Reset:** hold `rst` 2 cycles with `in_valid`=1.
  - Required: `in_ready`=0, `swap`=0, `rd_data`=0x00 during reset; `in_ready`=1 the cycle after release.
- **Load without frame (8×8):** stream 7E 40 7C 40 40 40 40 00 back-to-back, no `frame`.
  - Required: `in_ready`=0 and `pending`=1 after the 8th byte; `rd_data`=0x00 for every row; further bytes not accepted.
- **Swap:** with `pending`=1, pulse `frame` at edge E and set `rd_row`=2.
  - Required: `swap`=1 for one cycle after E; `rd_data`=0x7C after E+1; `loaded`=1, `pending`=0, `in_ready`=1.
- **Collision:** second image FF×8 with `in_valid` toggling every other cycle; 8th byte accepted on the same edge as `frame`.
  - Required: no swap; `rd_data` stays the first image (row 0 = 0x7E) throughout.
  - Required on the next `frame`: `swap`=1 and row 0 = 0xFF.
- **Reset mid-load:** assert `rst` after 3 bytes of a new image.
  - Required: `loaded`=0 and `rd_data`=0x00.
  - Then reload 8 bytes and pulse `frame`; required: `rd_row`=7 → the 8th byte.
- **Wide sprite (SPR_WIDTH=16, SPR_HEIGHT=4):** stream 12 34 56 78 9A BC DE F0, then `frame`.
  - Required: rows read 0x1234, 0x5678, 0x9ABC, 0xDEF0; `pending` rises only after the 8th byte.

Source files
------------

// File: rtl/sprite_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_loader_if
// Description : Bundle of the sprite loader's frame strobe, byte stream,
//               front-bank read port and status flags.
//               master - producer of bytes / renderer reading rows
//               slave  - the sprite loader itself
//   frame    : one-cycle pulse at start of vertical blanking
//   in_data  : bitmap byte
//   in_valid : in_data valid
//   in_ready : loader accepts a byte this cycle
//   rd_row   : front-bank row address
//   rd_data  : registered front-bank row, MSB = leftmost pixel
//   pending  : complete image waiting in the back bank
//   loaded   : front bank holds a valid image
//   swap     : one-cycle pulse, banks exchanged
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_loader_if #(
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8
);
  localparam int ROW_W = $clog2(SPR_HEIGHT);

  logic                 frame;
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROW_W-1:0]     rd_row;
  logic [SPR_WIDTH-1:0] rd_data;
  logic                 pending;
  logic                 loaded;
  logic                 swap;

  modport master (
    output frame, in_data, in_valid, rd_row,
    input  in_ready, rd_data, pending, loaded, swap
  );

  modport slave (
    input  frame, in_data, in_valid, rd_row,
    output in_ready, rd_data, pending, loaded, swap
  );
endinterface
`default_nettype wire

// File: rtl/sprite_loader.sv
`default_nettype none
// ============================================================================
// Module      : sprite_loader
// Description : Double-buffered sprite bitmap memory. A valid/ready byte
//               stream is assembled into rows and written to the back bank;
//               the banks exchange only on a frame pulse once a full image
//               is waiting, so the renderer never sees a half-written sprite.
// Ports       : clk - pixel clock
//               rst - synchronous active-high reset
//               bus - sprite_loader_if.slave (stream in, row read out, flags)
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_loader #(
  parameter int SPR_WIDTH  = 8,
  parameter int SPR_HEIGHT = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  sprite_loader_if.slave  bus
);

  localparam int BPR    = SPR_WIDTH / 8;
  localparam int ROW_W  = $clog2(SPR_HEIGHT);
  localparam int BYTE_W = (BPR > 1) ? $clog2(BPR) : 1;

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BPR - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SPR_HEIGHT - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [BYTE_W-1:0]    byte_cnt;
  logic [ROW_W-1:0]     row_cnt;
  logic                 bank_sel;
  logic                 loaded;
  logic                 swap;
  logic [SPR_WIDTH-1:0] rd_data;

  logic                 in_ready;
  logic                 pending;
  logic                 accept;
  logic                 swap_now;
  logic                 row_done;
  logic                 image_done;
  logic [SPR_WIDTH-1:0] row_word;
  logic [SPR_WIDTH-1:0] front_row;

  // Bank RAMs carry no reset; loaded=0 hides whatever they power up with.
  logic [SPR_WIDTH-1:0] bank0 [SPR_HEIGHT];
  logic [SPR_WIDTH-1:0] bank1 [SPR_HEIGHT];

  assign row_done   = (byte_cnt == LAST_BYTE);
  assign image_done = row_done && (row_cnt == LAST_ROW);

  // --------------------------------------------------------------------------
  // Row assembly. Earlier bytes of a row sit in a shift register; the final
  // byte is concatenated directly so the full row is written on the edge
  // that accepts it, with no extra pipeline stage.
  // --------------------------------------------------------------------------
  generate
    if (BPR > 1) begin : g_multi_byte
      logic [SPR_WIDTH-9:0] row_shift;

      always_ff @(posedge clk) begin
        if (rst) begin
          row_shift <= '0;
        end else if (accept) begin
          row_shift <= row_word[SPR_WIDTH-9:0];
        end
      end

      assign row_word = {row_shift, bus.in_data};
    end else begin : g_single_byte
      assign row_word = bus.in_data;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs. in_ready is gated by rst directly so no byte
  // can slip in while reset is held. A frame seen in LOAD is ignored, which
  // also covers the last byte landing on the same edge as a frame pulse.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pending   = 1'b0;
    accept    = 1'b0;
    swap_now  = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = !rst;
        accept   = !rst && bus.in_valid;
        if (accept && image_done) begin
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        pending = 1'b1;
        if (bus.frame) begin
          swap_now  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte / row counters. Both return to zero when the image completes so the
  // next load after a swap starts at row 0 byte 0.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      row_cnt  <= '0;
    end else if (accept) begin
      if (row_done) begin
        byte_cnt <= '0;
        row_cnt  <= image_done ? '0 : row_cnt + ROW_W'(1);
      end else begin
        byte_cnt <= byte_cnt + BYTE_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Back-bank write: always the bank not named by bank_sel.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && row_done) begin
      if (bank_sel) begin
        bank0[row_cnt] <= row_word;
      end else begin
        bank1[row_cnt] <= row_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bank select, status flags and registered front-bank read. rd_data uses
  // the pre-edge bank_sel/loaded, so the new bank shows from the edge after
  // the swap.
  // --------------------------------------------------------------------------
  assign front_row = bank_sel ? bank1[bus.rd_row] : bank0[bus.rd_row];

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel <= 1'b0;
      loaded   <= 1'b0;
      swap     <= 1'b0;
      rd_data  <= '0;
    end else begin
      swap    <= swap_now;
      rd_data <= loaded ? front_row : '0;
      if (swap_now) begin
        bank_sel <= ~bank_sel;
        loaded   <= 1'b1;
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.pending  = pending;
  assign bus.loaded   = loaded;
  assign bus.swap     = swap;
  assign bus.rd_data  = rd_data;

endmodule
`default_nettype wire
